// File: rtl/sdr_arb_pkg.sv
// Shared definitions for the SDRAM controller arbiter:
// state encodings, bus widths and SDRAM command codes.
package sdr_arb_pkg;

    localparam int ADDR_BITS = 12;
    localparam int BA_BITS   = 2;

    typedef enum logic [2:0] {
        ARB_INIT  = 3'd0,
        ARB_IDLE  = 3'd1,
        ARB_AREF  = 3'd2,
        ARB_WRITE = 3'd3,
        ARB_READ  = 3'd4
    } arb_state_t;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester drives and shared SDRAM bus seen by the arbiter.
// slave = arbiter side, master = requesters / bus consumer.
interface sdram_arbiter_if
    import sdr_arb_pkg::*;
#(
    parameter int AW = ADDR_BITS,
    parameter int BW = BA_BITS
);
    logic          init_done;
    logic [3:0]    init_cmd;
    logic [AW-1:0] init_addr;
    logic          aref_req;
    logic          aref_done;
    logic [3:0]    aref_cmd;
    logic [AW-1:0] aref_addr;
    logic          wr_req;
    logic          wr_rel;
    logic [3:0]    wr_cmd;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_ba;
    logic          rd_req;
    logic          rd_rel;
    logic [3:0]    rd_cmd;
    logic [AW-1:0] rd_addr;
    logic [BW-1:0] rd_ba;
    logic          aref_en;
    logic          wr_en;
    logic          rd_en;
    logic [3:0]    sdram_cmd;
    logic [AW-1:0] sdram_addr;
    logic [BW-1:0] sdram_ba;
    logic          sdram_cke;
    logic [2:0]    arb_state;

    modport slave (
        input  init_done, init_cmd, init_addr,
        input  aref_req, aref_done, aref_cmd, aref_addr,
        input  wr_req, wr_rel, wr_cmd, wr_addr, wr_ba,
        input  rd_req, rd_rel, rd_cmd, rd_addr, rd_ba,
        output aref_en, wr_en, rd_en,
        output sdram_cmd, sdram_addr, sdram_ba, sdram_cke,
        output arb_state
    );

    modport master (
        output init_done, init_cmd, init_addr,
        output aref_req, aref_done, aref_cmd, aref_addr,
        output wr_req, wr_rel, wr_cmd, wr_addr, wr_ba,
        output rd_req, rd_rel, rd_cmd, rd_addr, rd_ba,
        input  aref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_addr, sdram_ba, sdram_cke,
        input  arb_state
    );

endinterface

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker between write and read.
// On a tie the side not granted last wins.
module sdram_arb_rr (
    input  logic wr_req,
    input  logic rd_req,
    input  logic last_wr,
    output logic pick_wr,
    output logic pick_rd
);

    // Lone requester always wins; tie goes against last_wr.
    always_comb begin
        pick_wr = wr_req & (~rd_req | ~last_wr);
        pick_rd = rd_req & (~wr_req | last_wr);
    end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus scheduler: refresh first, then write/read
// round-robin; one-cycle grant pulses, combinational bus mux.
module sdram_arbiter
    import sdr_arb_pkg::*;
#(
    parameter int ADDR_BITS = sdr_arb_pkg::ADDR_BITS,
    parameter int BA_BITS   = sdr_arb_pkg::BA_BITS
) (
    input  logic            sdram_clk,
    input  logic            rst,
    sdram_arbiter_if.slave  bus
);

    arb_state_t state;
    logic       last_wr;
    logic       pick_wr;
    logic       pick_rd;

    sdram_arb_rr u_rr (
        .wr_req  (bus.wr_req),
        .rd_req  (bus.rd_req),
        .last_wr (last_wr),
        .pick_wr (pick_wr),
        .pick_rd (pick_rd)
    );

    // Ownership FSM with registered one-shot grant pulses.
    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state       <= ARB_INIT;
            last_wr     <= 1'b0;
            bus.aref_en <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.rd_en   <= 1'b0;
        end else begin
            bus.aref_en <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.rd_en   <= 1'b0;
            case (state)
                ARB_INIT: begin
                    if (bus.init_done)
                        state <= ARB_IDLE;
                end
                ARB_IDLE: begin
                    if (bus.aref_req) begin
                        state       <= ARB_AREF;
                        bus.aref_en <= 1'b1;
                    end else if (pick_wr) begin
                        state     <= ARB_WRITE;
                        bus.wr_en <= 1'b1;
                        last_wr   <= 1'b1;
                    end else if (pick_rd) begin
                        state     <= ARB_READ;
                        bus.rd_en <= 1'b1;
                        last_wr   <= 1'b0;
                    end
                end
                ARB_AREF: begin
                    if (bus.aref_done)
                        state <= ARB_IDLE;
                end
                ARB_WRITE: begin
                    if (bus.wr_rel)
                        state <= ARB_IDLE;
                end
                ARB_READ: begin
                    if (bus.rd_rel)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_INIT;
            endcase
        end
    end

    // Route the current owner's drive onto the SDRAM bus.
    always_comb begin
        bus.sdram_cmd  = CMD_NOP;
        bus.sdram_addr = '0;
        bus.sdram_ba   = '0;
        case (state)
            ARB_INIT: begin
                bus.sdram_cmd  = bus.init_cmd;
                bus.sdram_addr = bus.init_addr;
            end
            ARB_AREF: begin
                bus.sdram_cmd  = bus.aref_cmd;
                bus.sdram_addr = bus.aref_addr;
            end
            ARB_WRITE: begin
                bus.sdram_cmd  = bus.wr_cmd;
                bus.sdram_addr = bus.wr_addr;
                bus.sdram_ba   = bus.wr_ba;
            end
            ARB_READ: begin
                bus.sdram_cmd  = bus.rd_cmd;
                bus.sdram_addr = bus.rd_addr;
                bus.sdram_ba   = bus.rd_ba;
            end
            default: ;
        endcase
    end

    assign bus.sdram_cke = 1'b1;
    assign bus.arb_state = state;

endmodule
